// File: rtl/dlx_periph_pkg.sv
// Shared definitions for the DLX memory-mapped peripherals: register
// offsets, default timing constants and the register-select decode.
package dlx_periph_pkg;

    localparam logic [31:0] KEYS_STATE_OFF        = 32'h0;
    localparam logic [31:0] KEYS_EVENT_OFF        = 32'h4;
    localparam int          KEYS_DEBOUNCE_DEFAULT = 500000;

    typedef enum logic {
        REG_STATE  = 1'b0,
        REG_EVENTS = 1'b1
    } keys_reg_e;

    // Only address bit 2 distinguishes the two key registers; the offsets
    // above define which value of that bit selects which word.
    function automatic keys_reg_e keysRegDecode(input logic addrBit2);
        keys_reg_e sel;
        sel = REG_STATE;
        if (addrBit2 == KEYS_EVENT_OFF[2]) begin
            sel = REG_EVENTS;
        end else if (addrBit2 == KEYS_STATE_OFF[2]) begin
            sel = REG_STATE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-FF synchronizer on the raw active-low input,
// inversion to active-high, counter-based debounce and a press pulse that
// fires on the same edge the debounced level goes high.
module key_debounce
    import dlx_periph_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEYS_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_keyN,
    output logic o_stable,
    output logic o_rise
);

    logic             r_syncMeta;
    logic             r_syncOut;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sync;
    logic             w_expire;

    assign w_sync   = ~r_syncOut;
    assign w_expire = (w_sync != r_stable) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign o_stable = r_stable;
    assign o_rise   = w_expire & w_sync;

    // Synchronizer resets to the released level so no press is seen after reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_syncMeta <= 1'b1;
            r_syncOut  <= 1'b1;
        end else begin
            r_syncMeta <= i_keyN;
            r_syncOut  <= r_syncMeta;
        end
    end

    // Accept a new level only after it has held for the full count; any return restarts.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (w_sync == r_stable) begin
            r_cnt <= '0;
        end else if (w_expire) begin
            r_stable <= w_sync;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/driver_keys.sv
// Push-button peripheral: per-key debounce channels, sticky press flags with
// write-1-to-clear, and a two-word read port (STATE / EVENTS) on the data bus.
module driver_keys
    import dlx_periph_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = KEYS_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key,
    input  logic              chip_select,
    input  logic              write_enable,
    input  logic [31:0]       address,
    input  logic [31:0]       data_write,
    output logic [31:0]       data_read,
    output logic              key_event
);

    logic [N_KEYS-1:0] r_flags;
    logic [N_KEYS-1:0] w_stable;
    logic [N_KEYS-1:0] w_rise;
    logic [N_KEYS-1:0] w_clearMask;
    keys_reg_e         w_regSel;
    logic              w_unused;

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_debounce (
                .i_clk   (clk),
                .i_reset (reset),
                .i_keyN  (key[gi]),
                .o_stable(w_stable[gi]),
                .o_rise  (w_rise[gi])
            );
        end
    endgenerate

    assign w_regSel    = keysRegDecode(address[2]);
    assign w_clearMask = (chip_select && write_enable && (w_regSel == REG_EVENTS))
                         ? data_write[N_KEYS-1:0] : '0;
    assign key_event   = |r_flags;
    assign w_unused    = ^{address[31:3], address[1:0], data_write[31:N_KEYS]};

    // Sticky press flags: a new press on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= '0;
        end else begin
            r_flags <= (r_flags & ~w_clearMask) | w_rise;
        end
    end

    // Read mux; the bus sees zero whenever this peripheral is not selected.
    always_comb begin
        data_read = '0;
        if (chip_select) begin
            case (w_regSel)
                REG_STATE:  data_read[N_KEYS-1:0] = w_stable;
                REG_EVENTS: data_read[N_KEYS-1:0] = r_flags;
                default:    data_read = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_driver_keys.sv
// Scoreboard bench for driver_keys with a short debounce window: reads queue
// their expected bus word, and a monitor compares on each strobed cycle.
module tb_driver_keys;

    localparam int N_KEYS = 4;
    localparam int DEB    = 4;

    logic              clk;
    logic              reset;
    logic [N_KEYS-1:0] key;
    logic              chip_select;
    logic              write_enable;
    logic [31:0]       address;
    logic [31:0]       data_write;
    logic [31:0]       data_read;
    logic              key_event;

    logic              rdStrobe;

    typedef struct {
        logic [31:0] data;
        logic        evt;
        string       name;
    } exp_t;

    exp_t expQ[$];
    int   nChecks;
    int   nErrors;

    driver_keys #(
        .N_KEYS         (N_KEYS),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key         (key),
        .chip_select (chip_select),
        .write_enable(write_enable),
        .address     (address),
        .data_write  (data_write),
        .data_read   (data_read),
        .key_event   (key_event)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: on each strobed read cycle pop the oldest expectation and compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rdStrobe) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nErrors++;
                    $display("[TB] FAIL unexpected_read: got data_read=%08h with no expectation queued", data_read);
                end else begin
                    e = expQ.pop_front();
                    nChecks++;
                    if (data_read !== e.data) begin
                        nErrors++;
                        $display("[TB] FAIL %s data_read: got %08h expected %08h", e.name, data_read, e.data);
                    end
                    nChecks++;
                    if (key_event !== e.evt) begin
                        nErrors++;
                        $display("[TB] FAIL %s key_event: got %0b expected %0b", e.name, key_event, e.evt);
                    end
                end
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle read: queue the expected word, strobe the monitor for that cycle.
    task automatic checkOutput(input logic cs, input logic [31:0] addr,
                               input logic [31:0] expData, input logic expEvt,
                               input string name);
        exp_t e;
        e.data = expData;
        e.evt  = expEvt;
        e.name = name;
        expQ.push_back(e);
        chip_select  = cs;
        write_enable = 1'b0;
        address      = addr;
        rdStrobe     = 1'b1;
        tick(1);
        rdStrobe     = 1'b0;
        chip_select  = 1'b0;
        address      = 32'h0;
    endtask

    // One-cycle bus write; takes effect on the edge that ends the cycle.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        chip_select  = 1'b1;
        write_enable = 1'b1;
        address      = addr;
        data_write   = data;
        tick(1);
        chip_select  = 1'b0;
        write_enable = 1'b0;
        address      = 32'h0;
        data_write   = 32'h0;
    endtask

    // Directed sequence.
    initial begin
        int waitCycles;
        nChecks      = 0;
        nErrors      = 0;
        rdStrobe     = 1'b0;
        reset        = 1'b1;
        key          = 4'hF;
        chip_select  = 1'b0;
        write_enable = 1'b0;
        address      = 32'h0;
        data_write   = 32'h0;
        tick(3);
        reset = 1'b0;

        // Reset state, then idle keys raise nothing.
        checkOutput(1'b1, 32'h0, 32'h0, 1'b0, "reset_state");
        checkOutput(1'b1, 32'h4, 32'h0, 1'b0, "reset_events");
        for (int i = 0; i < 20; i++) begin
            checkOutput(1'b1, 32'h4, 32'h0, 1'b0, "idle_events");
        end

        // Short glitch on key[0] (3 cycles) is rejected.
        key = 4'b1110;
        tick(3);
        key = 4'hF;
        for (int i = 0; i < 4; i++) begin
            checkOutput(1'b1, 32'h0, 32'h0, 1'b0, "glitch_state");
            checkOutput(1'b1, 32'h4, 32'h0, 1'b0, "glitch_events");
        end

        // key[1] held: stable goes high on the 6th edge, not the 5th.
        key = 4'b1101;
        tick(5);
        checkOutput(1'b1, 32'h0, 32'h0, 1'b0, "press1_edge5");
        checkOutput(1'b1, 32'h0, 32'h2, 1'b1, "press1_edge6");
        checkOutput(1'b1, 32'h4, 32'h2, 1'b1, "press1_events");

        // Add key[0], then W1C bit 0 and a write to the read-only STATE word.
        key = 4'b1100;
        tick(6);
        checkOutput(1'b1, 32'h4, 32'h3, 1'b1, "two_flags");
        applyStimulus(32'h4, 32'h1);
        checkOutput(1'b1, 32'h4, 32'h2, 1'b1, "w1c_bit0");
        applyStimulus(32'h0, 32'hF);
        checkOutput(1'b1, 32'h4, 32'h2, 1'b1, "state_write_ignored");
        checkOutput(1'b1, 32'h0, 32'h3, 1'b1, "state_after_write");

        // Clear of flag 2 on the same edge it is set: the set wins.
        key = 4'b1000;
        tick(5);
        applyStimulus(32'h4, 32'h4);
        checkOutput(1'b1, 32'h4, 32'h6, 1'b1, "set_beats_clear");
        checkOutput(1'b1, 32'h0, 32'h7, 1'b1, "state_three_held");

        // Deselected reads return zero regardless of state.
        checkOutput(1'b0, 32'h4, 32'h0, 1'b1, "cs0_events");
        checkOutput(1'b0, 32'h0, 32'h0, 1'b1, "cs0_state");

        // Reset mid-debounce of key[3]; held key is re-debounced afterwards.
        key = 4'b0111;
        tick(3);
        reset = 1'b1;
        tick(1);
        checkOutput(1'b1, 32'h4, 32'h0, 1'b0, "in_reset_events");
        reset = 1'b0;
        tick(5);
        checkOutput(1'b1, 32'h4, 32'h0, 1'b0, "post_reset_edge5");
        checkOutput(1'b1, 32'h4, 32'h8, 1'b1, "post_reset_edge6");
        checkOutput(1'b1, 32'h0, 32'h8, 1'b1, "post_reset_state");

        // Drain the scoreboard with a bounded wait.
        waitCycles = 0;
        while (expQ.size() != 0 && waitCycles < 10) begin
            tick(1);
            waitCycles++;
        end
        if (expQ.size() != 0) begin
            nChecks++;
            nErrors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
